// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, holding
// operands for a per-function multicycle window. Optional divide-by-zero trap: ALU_ARB_DIV0_TRAP_EN.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_fn,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_fn,
  output logic        req1_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_result,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        div0_err,
  output logic        busy
);

  localparam logic [5:0] alu_ADD = 6'h00;
  localparam logic [5:0] alu_MUL = 6'h0A;
  localparam logic [5:0] alu_DIV = 6'h0B;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic        id_q, id_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [5:0]  alu_fn_q, alu_fn_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;

  logic        win_id;
  logic        accept;
  logic [31:0] win_a, win_b;
  logic [5:0]  win_fn;
  logic [7:0]  lat_m1;

  // Arbitration: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    win_id     = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
    accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
    win_a      = win_id ? req1_a  : req0_a;
    win_b      = win_id ? req1_b  : req0_b;
    win_fn     = win_id ? req1_fn : req0_fn;
  end

  always_comb begin
    lat_m1 = 8'd0;
    if (win_fn == alu_MUL) lat_m1 = 8'(MUL_CYCLES - 1);
    if (win_fn == alu_DIV) lat_m1 = 8'(DIV_CYCLES - 1);
`ifdef ALU_ARB_DIV0_TRAP_EN
    if (win_fn == alu_DIV && win_b == 32'd0) lat_m1 = 8'd0;
`endif
  end

`ifdef ALU_ARB_DIV0_TRAP_EN
  logic div0_pend_q, div0_pend_d;
  logic div0_err_q, div0_err_d;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fn_d    = alu_fn_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 2'b00;
`ifdef ALU_ARB_DIV0_TRAP_EN
    div0_pend_d = div0_pend_q;
    div0_err_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d   = win_a;
          alu_b_d   = win_b;
          alu_fn_d  = win_fn;
          id_d      = win_id;
          rr_last_d = win_id;
          cnt_d     = lat_m1;
          state_d   = EXEC;
`ifdef ALU_ARB_DIV0_TRAP_EN
          div0_pend_d = (win_fn == alu_DIV) && (win_b == 32'd0);
`endif
        end
      end
      EXEC: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rsp_data_d  = alu_result;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          state_d     = DONE;
`ifdef ALU_ARB_DIV0_TRAP_EN
          if (div0_pend_q) rsp_data_d = 32'hFFFF_FFFF;
          div0_err_d = div0_pend_q;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= 8'd0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_fn_q    <= alu_ADD;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 2'b00;
`ifdef ALU_ARB_DIV0_TRAP_EN
      div0_pend_q <= 1'b0;
      div0_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fn_q    <= alu_fn_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ALU_ARB_DIV0_TRAP_EN
      div0_pend_q <= div0_pend_d;
      div0_err_q  <= div0_err_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fn    = alu_fn_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);
`ifdef ALU_ARB_DIV0_TRAP_EN
  assign div0_err  = div0_err_q;
`else
  assign div0_err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU on the operand bus.
module tb_alu_arbiter;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 8;
  localparam logic [5:0] F_ADD = 6'h00;
  localparam logic [5:0] F_SUB = 6'h01;
  localparam logic [5:0] F_XOR = 6'h04;
  localparam logic [5:0] F_MUL = 6'h0A;
  localparam logic [5:0] F_DIV = 6'h0B;
  localparam logic [31:0] DIV0_ALU = 32'h0BAD_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]  req0_fn = '0, req1_fn = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic [5:0]  alu_fn;
  logic [1:0]  rsp_valid;
  logic        div0_err, busy;

  int n_vec  = 0;
  int n_miss = 0;

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .div0_err(div0_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting on the shared bus.
  always_comb begin
    alu_result = 32'd0;
    case (alu_fn)
      F_ADD: alu_result = alu_a + alu_b;
      F_SUB: alu_result = alu_a - alu_b;
      F_XOR: alu_result = alu_a ^ alu_b;
      F_MUL: alu_result = alu_a * alu_b;
      F_DIV: alu_result = (alu_b == 32'd0) ? DIV0_ALU : 32'($signed(alu_a) / $signed(alu_b));
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fn);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_fn = fn;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_fn = fn;
    end
  endtask

  task automatic reset_dut();
    drive(0, 1'b0, 32'd0, 32'd0, F_ADD);
    drive(1, 1'b0, 32'd0, 32'd0, F_ADD);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One op from a single requester; exp_lat is the hold window, response expected at accept+exp_lat+1.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn,
                       input logic [31:0] exp_data, input int exp_lat, input logic exp_div0);
    int k;
    @(negedge clk);
    drive(id, 1'b1, a, b, fn);
    #1;
    check("ready_win", (id == 0) ? req0_ready : req1_ready, 1);
    check("ready_other", (id == 0) ? req1_ready : req0_ready, 0);
    @(negedge clk);
    drive(id, 1'b0, a, b, fn);
    k = 1;
    while (rsp_valid == 2'b00 && k <= exp_lat + 4) begin
      check("hold_a", alu_a, a);
      check("hold_b", alu_b, b);
      check("hold_fn", {26'd0, alu_fn}, {26'd0, fn});
      check("busy_exec", busy, 1);
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_lat + 1);
    check("rsp_valid", {30'd0, rsp_valid}, (id == 0) ? 32'd1 : 32'd2);
    check("rsp_data", rsp_data, exp_data);
    check("div0_err", div0_err, exp_div0);
    check("busy_done", busy, 1);
    @(negedge clk);
    check("rsp_pulse_end", {30'd0, rsp_valid}, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants, rsps;
    reset_dut();
    #1;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_fn", {26'd0, alu_fn}, {26'd0, F_ADD});
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 0);
    check("rst_div0", div0_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready0", req0_ready, 0);

    do_op(0, 32'd5, 32'd7, F_ADD, 32'd12, 1, 1'b0);
    do_op(1, 32'd100, 32'd7, F_DIV, 32'd14, DIV_CYCLES, 1'b0);
    do_op(0, -32'sd3, 32'd6, F_MUL, 32'hFFFF_FFEE, MUL_CYCLES, 1'b0);
    check("idle_keeps_fn", {26'd0, alu_fn}, {26'd0, F_MUL});

    // Contention: both requesters hold valid; after reset requester 0 wins first.
    reset_dut();
    drive(0, 1'b1, 32'd10, 32'd3, F_SUB);
    drive(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, F_XOR);
    grants = 0;
    rsps   = 0;
    for (int c = 0; c < 60 && rsps < 4; c++) begin
      #1;
      check("one_ready", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        check("grant_order", req1_ready, grants % 2);
        grants++;
      end
      if (rsp_valid != 2'b00) begin
        check("cont_rsp_id", {30'd0, rsp_valid}, (rsps % 2 == 0) ? 32'd1 : 32'd2);
        check("cont_rsp_data", rsp_data, (rsps % 2 == 0) ? 32'd7 : 32'hFF);
        rsps++;
      end
      @(negedge clk);
      if (grants == 4) begin
        drive(0, 1'b0, 32'd0, 32'd0, F_ADD);
        drive(1, 1'b0, 32'd0, 32'd0, F_ADD);
      end
    end
    check("cont_grants", grants, 4);
    check("cont_rsps", rsps, 4);

    // Reset three cycles into a DIV.
    @(negedge clk);
    drive(1, 1'b1, 32'd100, 32'd7, F_DIV);
    #1;
    check("mid_ready", req1_ready, 1);
    @(negedge clk);
    drive(1, 1'b0, 32'd0, 32'd0, F_ADD);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_alu_a", alu_a, 0);
    check("mid_alu_b", alu_b, 0);
    check("mid_alu_fn", {26'd0, alu_fn}, {26'd0, F_ADD});
    check("mid_rsp_data", rsp_data, 0);
    check("mid_rsp_valid", {30'd0, rsp_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("mid_no_rsp", {30'd0, rsp_valid}, 0);
    end
    do_op(0, 32'd20, 32'd22, F_ADD, 32'd42, 1, 1'b0);

`ifdef ALU_ARB_DIV0_TRAP_EN
    do_op(0, 32'd9, 32'd0, F_DIV, 32'hFFFF_FFFF, 1, 1'b1);
`else
    do_op(0, 32'd9, 32'd0, F_DIV, DIV0_ALU, DIV_CYCLES, 1'b0);
`endif
    do_op(1, 32'd1, 32'd2, F_ADD, 32'd3, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
